// File: rtl/circle_raster.sv
// Midpoint circle rasteriser: streams clipped outline or filled-disc
// pixels over a valid/ready beat interface, then pulses done.
module circle_raster #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      cx,
  input  logic [Y_W-1:0]      cy,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                fill,
  output logic                busy,
  output logic                done,
  output logic                pvalid,
  input  logic                pready,
  output logic [X_W-1:0]      px,
  output logic [Y_W-1:0]      py,
  output logic [COLOUR_W-1:0] pcolour
);

  localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int CW   = ((XY_W > R_W) ? XY_W : R_W) + 2;
  localparam int DW   = R_W + 4;

  localparam logic signed [CW-1:0] SW = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH = CW'(SCREEN_H);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]             state;
  logic signed [CW-1:0]   cx_q;
  logic signed [CW-1:0]   cy_q;
  logic signed [CW-1:0]   x_q;
  logic signed [CW-1:0]   y_q;
  logic signed [CW-1:0]   col_q;
  logic signed [DW-1:0]   d_q;
  logic                   fill_q;
  logic [2:0]             idx_q;

  logic                   free;
  logic                   in_range;
  logic                   span_end;
  logic                   last_c;
  logic                   more;
  logic signed [CW-1:0]   cand_x;
  logic signed [CW-1:0]   cand_y;
  logic signed [CW-1:0]   span_hi;
  logic signed [CW-1:0]   next_lo;
  logic signed [CW-1:0]   x_nx;
  logic signed [CW-1:0]   y_nx;
  logic signed [DW-1:0]   xd;
  logic signed [DW-1:0]   yd;
  logic signed [DW-1:0]   d_nx;

  // Output register may take a new candidate when empty or draining.
  assign free = !pvalid || pready;

  always_comb begin
    cand_x  = '0;
    cand_y  = '0;
    span_hi = '0;
    next_lo = cx_q - y_q;
    if (fill_q) begin
      cand_x = col_q;
      unique case (idx_q[1:0])
        2'd0: begin
          cand_y  = cy_q + y_q;
          span_hi = cx_q + x_q;
          next_lo = cx_q - x_q;
        end
        2'd1: begin
          cand_y  = cy_q - y_q;
          span_hi = cx_q + x_q;
        end
        2'd2: begin
          cand_y  = cy_q + x_q;
          span_hi = cx_q + y_q;
        end
        default: begin
          cand_y  = cy_q - x_q;
          span_hi = cx_q + y_q;
        end
      endcase
    end else begin
      unique case (idx_q)
        3'd0: begin cand_x = cx_q + x_q; cand_y = cy_q + y_q; end
        3'd1: begin cand_x = cx_q + x_q; cand_y = cy_q - y_q; end
        3'd2: begin cand_x = cx_q - x_q; cand_y = cy_q + y_q; end
        3'd3: begin cand_x = cx_q - x_q; cand_y = cy_q - y_q; end
        3'd4: begin cand_x = cx_q + y_q; cand_y = cy_q + x_q; end
        3'd5: begin cand_x = cx_q + y_q; cand_y = cy_q - x_q; end
        3'd6: begin cand_x = cx_q - y_q; cand_y = cy_q + x_q; end
        default: begin cand_x = cx_q - y_q; cand_y = cy_q - x_q; end
      endcase
    end
  end

  assign span_end = (col_q == span_hi);
  assign last_c   = fill_q ? (idx_q[1:0] == 2'd3 && span_end)
                           : (idx_q == 3'd7);
  assign in_range = !cand_x[CW-1] && (cand_x < SW) &&
                    !cand_y[CW-1] && (cand_y < SH);

  assign xd   = DW'(x_q);
  assign yd   = DW'(y_q);
  assign d_nx = d_q[DW-1] ? d_q + (xd <<< 2) + DW'(6)
                          : d_q + ((xd - yd) <<< 2) + DW'(10);
  assign x_nx = x_q + CW'(1);
  assign y_nx = d_q[DW-1] ? y_q : y_q - CW'(1);
  assign more = (x_nx <= y_nx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pvalid  <= 1'b0;
      px      <= '0;
      py      <= '0;
      pcolour <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      d_q     <= '0;
      fill_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      done <= 1'b0;
      if (pvalid && pready) begin
        pvalid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            cx_q    <= CW'(cx);
            cy_q    <= CW'(cy);
            x_q     <= '0;
            y_q     <= CW'(radius);
            col_q   <= CW'(cx);
            d_q     <= DW'(3) - DW'({radius, 1'b0});
            pcolour <= colour;
            fill_q  <= fill;
            idx_q   <= '0;
            busy    <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (free) begin
            pvalid <= in_range;
            if (in_range) begin
              px <= cand_x[X_W-1:0];
              py <= cand_y[Y_W-1:0];
            end
            if (fill_q) begin
              if (span_end) begin
                idx_q <= idx_q + 3'd1;
                col_q <= next_lo;
              end else begin
                col_q <= col_q + CW'(1);
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
            if (last_c) begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          if (free) begin
            d_q   <= d_nx;
            x_q   <= x_nx;
            y_q   <= y_nx;
            idx_q <= '0;
            col_q <= cx_q - x_nx;
            if (more) begin
              state <= EMIT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
